// File: rtl/aer_spike_arbiter.sv
// AER spike arbiter: captures per-channel spike pulses with a prescaled
// timestamp, round-robin arbitrates pending channels and emits one
// registered {channel, timestamp} word per grant.
// Optional macro AER_DROP_CNT_EN enables the overrun drop counter and the
// sticky overflow flag; without it both outputs are tied to zero.
module aer_spike_arbiter #(
    parameter int unsigned NUM_CH      = 16,
    parameter int unsigned CH_W        = 4,
    parameter int unsigned TS_W        = 20,
    parameter int unsigned TS_PRESCALE = 1,
    parameter int unsigned DROP_W      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic [NUM_CH-1:0]      spike_req_i,
    input  logic                   fifo_full_i,
    output logic [CH_W+TS_W-1:0]   data_o,
    output logic                   aer_valid_o,
    output logic                   busy_o,
    output logic [DROP_W-1:0]      drop_count_o,
    output logic                   overflow_o
);

    localparam int unsigned PscW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PscW-1:0]       psc_q, psc_d;
    logic [TS_W-1:0]       ts_q, ts_d;
    logic                  tick;
    logic [NUM_CH-1:0]     pending_q, pending_d;
    logic [TS_W-1:0]       ts_hold_q [NUM_CH];
    logic [TS_W-1:0]       ts_hold_d [NUM_CH];
    logic [IdxW-1:0]       rr_q, rr_d;
    logic [CH_W+TS_W-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  gnt_found;
    logic                  gnt_valid;
    logic [IdxW-1:0]       gnt_idx;
    logic [IdxW:0]         scan_idx;
    logic [NUM_CH-1:0]     drop_vec;

    assign tick = (psc_q == PscW'(TS_PRESCALE - 1));

    // Free-running prescaler and timestamp counter (wraps silently)
    always_comb begin
        psc_d = tick ? '0 : psc_q + 1'b1;
        ts_d  = tick ? ts_q + 1'b1 : ts_q;
    end

    // Round-robin search: first pending channel at or above rr pointer, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            scan_idx = {1'b0, rr_q} + (IdxW+1)'(off);
            if (scan_idx >= (IdxW+1)'(NUM_CH)) begin
                scan_idx = scan_idx - (IdxW+1)'(NUM_CH);
            end
            if (!gnt_found && pending_q[scan_idx[IdxW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[IdxW-1:0];
            end
        end
    end

    assign gnt_valid = enable_i && !fifo_full_i && gnt_found;

    // Pending capture, overrun detection and grant clear per channel
    always_comb begin
        pending_d = pending_q;
        ts_hold_d = ts_hold_q;
        drop_vec  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (spike_req_i[i]) begin
                // A grant frees the slot this cycle, so a coincident spike re-arms it
                if (!pending_q[i] || (gnt_valid && gnt_idx == IdxW'(i))) begin
                    pending_d[i] = 1'b1;
                    ts_hold_d[i] = ts_q;
                end else begin
                    drop_vec[i] = 1'b1;
                end
            end else if (gnt_valid && gnt_idx == IdxW'(i)) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Output word register and round-robin pointer advance
    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        rr_d    = rr_q;
        if (gnt_valid) begin
            data_d  = {CH_W'(gnt_idx), ts_hold_q[gnt_idx]};
            valid_d = 1'b1;
            rr_d    = (gnt_idx == IdxW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            psc_q     <= '0;
            ts_q      <= '0;
            pending_q <= '0;
            rr_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ts_hold_q[i] <= '0;
            end
        end else begin
            psc_q     <= psc_d;
            ts_q      <= ts_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ts_hold_q[i] <= ts_hold_d[i];
            end
        end
    end

    assign data_o      = data_q;
    assign aer_valid_o = valid_q;
    assign busy_o      = |pending_q;

`ifdef AER_DROP_CNT_EN
    localparam int unsigned NcW  = $clog2(NUM_CH + 1);
    localparam int unsigned SumW = DROP_W + NcW;

    logic [NcW-1:0]    ndrop;
    logic [SumW-1:0]   drop_sum;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ovf_q, ovf_d;

    // Add all same-cycle drops at once, saturating at all-ones
    always_comb begin
        ndrop = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ndrop = ndrop + NcW'(drop_vec[i]);
        end
        drop_sum = SumW'(drop_q) + SumW'(ndrop);
        drop_d   = (|drop_sum[SumW-1:DROP_W]) ? '1 : drop_sum[DROP_W-1:0];
        ovf_d    = ovf_q | (|drop_vec);
    end

    // Drop counter and sticky overflow registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    assign drop_count_o = drop_q;
    assign overflow_o   = ovf_q;
`else
    // Overruns still lose the new spike; only the accounting is absent
    logic unused_drop;
    assign unused_drop  = ^drop_vec;
    assign drop_count_o = '0;
    assign overflow_o   = 1'b0;
`endif

endmodule
